// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: widths, FU port indices, station encoding.
// Used by cdb_writeback and cdb_arbiter (optional macro CDB_RR_EN).
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int NUM_FU = 3;

  localparam int FU_F0 = 0;
  localparam int FU_F1 = 1;
  localparam int FU_F3 = 2;

  localparam int   STN_BIT = TAG_W - 1;
  localparam logic STN_ADD = 1'b0;
  localparam logic STN_MUL = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ARB  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cdb_arbiter.sv
// One-hot CDB grant over occupied holding buffers.
// CDB_RR_EN: round-robin with pointer; otherwise fixed F3 > F0 > F1.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_FU = tomasulo_pkg::NUM_FU
) (
`ifdef CDB_RR_EN
  input  logic              clk,
  input  logic              rst,
`endif
  input  logic [NUM_FU-1:0] occupied,
  output logic [NUM_FU-1:0] grant
);

`ifdef CDB_RR_EN
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0] ptr;
  logic             found;

  function automatic int rr_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NUM_FU) ? s - NUM_FU : s;
  endfunction

  // first occupied buffer at or after the pointer wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!found && occupied[rr_idx(int'(ptr), k)]) begin
        grant[rr_idx(int'(ptr), k)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // pointer moves just past the last winner
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      for (int p = 0; p < NUM_FU; p++) begin
        if (grant[p]) begin
          ptr <= (p == NUM_FU - 1) ? '0 : PTR_W'(p + 1);
        end
      end
    end
  end
`else
  logic found;

  // F3 first, then the remaining ports in ascending order
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (occupied[FU_F3]) begin
      grant[FU_F3] = 1'b1;
      found = 1'b1;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (i != FU_F3 && !found && occupied[i]) begin
        grant[i] = 1'b1;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_writeback.sv
// Per-FU holding buffers feeding a registered common data bus.
// Arbitration order selected by macro CDB_RR_EN (see cdb_arbiter).
module cdb_writeback
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int NUM_FU = tomasulo_pkg::NUM_FU
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_value,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic [1:0]               cdb_fu
);

  logic [NUM_FU-1:0] buf_valid;
  logic [TAG_W-1:0]  buf_tag   [NUM_FU];
  logic [DATA_W-1:0] buf_value [NUM_FU];

  logic [NUM_FU-1:0] arb_grant;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] load;
  logic [NUM_FU-1:0] occ_next;

  logic [1:0]        grant_idx;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] grant_value;

  arb_state_e state;
  arb_state_e state_next;

  cdb_arbiter #(
    .NUM_FU   (NUM_FU)
  ) u_arb (
`ifdef CDB_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .occupied (buf_valid),
    .grant    (arb_grant)
  );

  // a slot accepts when empty or when it drains this cycle
  always_comb begin
    grant    = (state == ARB) ? arb_grant : '0;
    fu_ready = ~buf_valid | grant;
    load     = fu_valid & fu_ready;
    occ_next = (buf_valid & ~grant) | load;
  end

  // select the winning buffer's contents for the bus register
  always_comb begin
    grant_idx   = '0;
    grant_tag   = '0;
    grant_value = '0;
    for (int p = 0; p < NUM_FU; p++) begin
      if (grant[p]) begin
        grant_idx   = 2'(p);
        grant_tag   = buf_tag[p];
        grant_value = buf_value[p];
      end
    end
  end

  // IDLE while nothing is buffered, ARB otherwise
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (|load)     state_next = ARB;
      ARB:  if (~|occ_next) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // arbiter state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // load wins over drain so a reloaded slot stays full
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_FU; p++) begin
        if (load[p])       buf_valid[p] <= 1'b1;
        else if (grant[p]) buf_valid[p] <= 1'b0;
      end
    end
  end

  // payload capture; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_FU; p++) begin
      if (load[p]) begin
        buf_tag[p]   <= fu_tag[p*TAG_W +: TAG_W];
        buf_value[p] <= fu_value[p*DATA_W +: DATA_W];
      end
    end
  end

  // bus register: strobe per grant, payload held between grants
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_fu    <= '0;
    end else begin
      cdb_valid <= |grant;
      if (|grant) begin
        cdb_tag   <= grant_tag;
        cdb_value <= grant_value;
        cdb_fu    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: vector table plus multi-cycle sequences.
// Expected orders follow CDB_RR_EN when defined.
module tb_cdb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fu_valid;
  logic [8:0]  fu_tag;
  logic [47:0] fu_value;
  logic [2:0]  fu_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic [1:0]  cdb_fu;

  int checks = 0;
  int errors = 0;

  cdb_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_fu    (cdb_fu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [8:0]  tag;
    logic [47:0] val;
    logic [2:0]  rdy;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cval;
    logic [1:0]  cfu;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  localparam logic [8:0]  G9  = 9'h1FF;
  localparam logic [47:0] G48 = 48'hDEAD_BEEF_F00D;

  function automatic vec_t mk(
    input logic r, input logic [2:0] v,
    input logic [8:0] t, input logic [47:0] d,
    input logic [2:0] rdy, input logic cv,
    input logic [2:0] ct, input logic [15:0] cval,
    input logic [1:0] cfu);
    vec_t x;
    x.rst = r; x.v = v; x.tag = t; x.val = d;
    x.rdy = rdy; x.cv = cv; x.ct = ct;
    x.cval = cval; x.cfu = cfu;
    return x;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] v,
                      input logic [8:0] t, input logic [47:0] d);
    @(negedge clk);
    rst = r; fu_valid = v; fu_tag = t; fu_value = d;
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  ord_fu [3];
  logic [2:0]  a_tag  [3];
  logic [15:0] a_val  [3];
  logic [2:0]  a_rdy;

  logic [1:0]  b_fu   [5];
  logic [15:0] b_val  [5];
  logic        b_rdy0 [5];
  logic [15:0] q0 [3];
  logic [15:0] q3 [2];
  logic [1:0]  got_fu  [8];
  logic [15:0] got_val [8];

  initial begin
    int h0, h3, n;
    logic acc0, acc3;

    rst = 1'b1; fu_valid = '0; fu_tag = '0; fu_value = '0;

    vecs[0]  = mk(1, 3'b000, G9, G48, 3'b111, 0, 3'b000, 16'h0000, 0);
    vecs[1]  = mk(0, 3'b001, {3'h7, 3'h7, 3'b001},
                  {16'hFFFF, 16'hFFFF, 16'h0005},
                  3'b111, 0, 3'b000, 16'h0000, 0);
    vecs[2]  = mk(0, 3'b000, G9, G48, 3'b111, 1, 3'b001, 16'h0005, 0);
    vecs[3]  = mk(0, 3'b000, G9, G48, 3'b111, 0, 3'b001, 16'h0005, 0);
    vecs[4]  = mk(0, 3'b010, {3'h7, 3'b010, 3'h7},
                  {16'hFFFF, 16'hAAAA, 16'hFFFF},
                  3'b111, 0, 3'b001, 16'h0005, 0);
    vecs[5]  = mk(0, 3'b010, {3'h7, 3'b010, 3'h7},
                  {16'hFFFF, 16'h5555, 16'hFFFF},
                  3'b111, 1, 3'b010, 16'hAAAA, 1);
    vecs[6]  = mk(0, 3'b010, {3'h7, 3'b010, 3'h7},
                  {16'hFFFF, 16'hAAAA, 16'hFFFF},
                  3'b111, 1, 3'b010, 16'h5555, 1);
    vecs[7]  = mk(0, 3'b010, {3'h7, 3'b010, 3'h7},
                  {16'hFFFF, 16'h5555, 16'hFFFF},
                  3'b111, 1, 3'b010, 16'hAAAA, 1);
    vecs[8]  = mk(0, 3'b000, G9, G48, 3'b111, 1, 3'b010, 16'h5555, 1);
    vecs[9]  = mk(0, 3'b000, G9, G48, 3'b111, 0, 3'b010, 16'h5555, 1);
    vecs[10] = mk(0, 3'b101, {3'b100, 3'h7, 3'b000},
                  {16'h3333, 16'hFFFF, 16'h1111},
                  3'b110, 0, 3'b010, 16'h5555, 1);
    vecs[11] = mk(1, 3'b000, G9, G48, 3'b111, 0, 3'b000, 16'h0000, 0);
    vecs[12] = mk(0, 3'b000, G9, G48, 3'b111, 0, 3'b000, 16'h0000, 0);
    vecs[13] = mk(0, 3'b010, {3'h7, 3'b011, 3'h7},
                  {16'hFFFF, 16'h0777, 16'hFFFF},
                  3'b111, 0, 3'b000, 16'h0000, 0);
    vecs[14] = mk(0, 3'b000, G9, G48, 3'b111, 1, 3'b011, 16'h0777, 1);
    vecs[15] = mk(0, 3'b100, {3'b101, 3'h7, 3'h7},
                  {16'h0E00, 16'hFFFF, 16'hFFFF},
                  3'b111, 0, 3'b011, 16'h0777, 1);
    vecs[16] = mk(0, 3'b000, G9, G48, 3'b111, 1, 3'b101, 16'h0E00, 2);
    for (int i = 17; i < NV; i++)
      vecs[i] = mk(0, 3'b000, G9, G48, 3'b111, 0, 3'b101, 16'h0E00, 2);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].tag, vecs[i].val);
      chk("fu_ready", i, 48'(fu_ready), 48'(vecs[i].rdy));
      chk("cdb_valid", i, 48'(cdb_valid), 48'(vecs[i].cv));
      chk("cdb_tag", i, 48'(cdb_tag), 48'(vecs[i].ct));
      chk("cdb_value", i, 48'(cdb_value), 48'(vecs[i].cval));
      chk("cdb_fu", i, 48'(cdb_fu), 48'(vecs[i].cfu));
    end

    // three simultaneous results from reset
    a_tag = '{3'b000, 3'b010, 3'b100};
    a_val = '{16'h0011, 16'h0022, 16'h0C00};
`ifdef CDB_RR_EN
    ord_fu = '{2'd0, 2'd1, 2'd2};
    a_rdy  = 3'b001;
`else
    ord_fu = '{2'd2, 2'd0, 2'd1};
    a_rdy  = 3'b100;
`endif
    step(1, 3'b000, G9, G48);
    step(0, 3'b111, {3'b100, 3'b010, 3'b000},
         {16'h0C00, 16'h0022, 16'h0011});
    chk("a_load_valid", 0, 48'(cdb_valid), 48'(0));
    chk("a_load_ready", 0, 48'(fu_ready), 48'(a_rdy));
    for (int k = 0; k < 3; k++) begin
      step(0, 3'b000, G9, G48);
      chk("a_valid", k, 48'(cdb_valid), 48'(1));
      chk("a_fu", k, 48'(cdb_fu), 48'(ord_fu[k]));
      chk("a_tag", k, 48'(cdb_tag), 48'(a_tag[ord_fu[k]]));
      chk("a_value", k, 48'(cdb_value), 48'(a_val[ord_fu[k]]));
    end
    step(0, 3'b000, G9, G48);
    chk("a_drained", 0, 48'(cdb_valid), 48'(0));

    // backpressure: F0 keeps offering while F3 is also buffered
    q0 = '{16'h0100, 16'h0101, 16'h0102};
    q3 = '{16'h0300, 16'h0301};
`ifdef CDB_RR_EN
    b_fu   = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    b_val  = '{16'h0100, 16'h0300, 16'h0101, 16'h0301, 16'h0102};
    b_rdy0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    b_fu   = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    b_val  = '{16'h0300, 16'h0301, 16'h0100, 16'h0101, 16'h0102};
    b_rdy0 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    step(1, 3'b000, G9, G48);
    h0 = 0; h3 = 0; n = 0;
    for (int e = 0; e < 7; e++) begin
      @(negedge clk);
      rst = 1'b0;
      fu_valid = {h3 < 2, 1'b0, h0 < 3};
      fu_tag   = {3'b100, 3'h7, 3'b000};
      fu_value = {q3[(h3 < 2) ? h3 : 0], 16'hFFFF,
                  q0[(h0 < 3) ? h0 : 0]};
      acc0 = fu_valid[0] & fu_ready[0];
      acc3 = fu_valid[2] & fu_ready[2];
      @(posedge clk);
      #1;
      if (acc0) h0++;
      if (acc3) h3++;
      if (cdb_valid && n < 8) begin
        got_fu[n]  = cdb_fu;
        got_val[n] = cdb_value;
        n++;
      end
      if (e < 5) chk("b_ready0", e, 48'(fu_ready[0]), 48'(b_rdy0[e]));
    end
    chk("b_count", 0, 48'(n), 48'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < n) begin
        chk("b_fu", k, 48'(got_fu[k]), 48'(b_fu[k]));
        chk("b_value", k, 48'(got_val[k]), 48'(b_val[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
